// File: rtl/vga_if.sv
// vga_if: VGA timing and pixel bundle passed between draw-chain stages.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport vga_in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport vga_out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/hp_bar_array.sv
// hp_bar_array: per-player HP, ghost bar and hit-immunity tracking with a registered bar overlay.
// Optional feature macro HP_BAR_FLASH_EN: HP region flashes white while a player is immune.
module hp_bar_array #(
    parameter int unsigned N_PLAYERS   = 2,
    parameter int unsigned HP_W        = 10,
    parameter int unsigned HEALTH_MAX  = 500,
    parameter int unsigned HEAL_AMT    = 25,
    parameter int unsigned IFRAMES     = 30,
    parameter int unsigned DRAIN_STEP  = 2,
    parameter int unsigned BAR_X0      = 8,
    parameter int unsigned BAR_PITCH   = 508,
    parameter int unsigned BAR_Y_START = 6,
    parameter int unsigned BAR_Y_END   = 26,
    parameter logic [11:0] BAR_COLOR   = 12'hF00,
    parameter logic [11:0] GHOST_COLOR = 12'hFF0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        round_rst_i,
    input  logic [N_PLAYERS-1:0]        hit_i,
    input  logic [HP_W-1:0]             dmg_i,
    input  logic [N_PLAYERS-1:0]        heal_i,
    output logic [N_PLAYERS*HP_W-1:0]   hp_o,
    output logic [N_PLAYERS-1:0]        dead_o,
    output logic [N_PLAYERS-1:0]        immune_o,
    vga_if.vga_in                       vga_in,
    vga_if.vga_out                      vga_out
);

    localparam int unsigned IfW = $clog2(IFRAMES + 1);
    localparam int unsigned XW  = 16;

    logic [HP_W-1:0]      hp_q     [N_PLAYERS];
    logic [HP_W-1:0]      hp_d     [N_PLAYERS];
    logic [HP_W-1:0]      ghost_q  [N_PLAYERS];
    logic [HP_W-1:0]      ghost_d  [N_PLAYERS];
    logic [IfW-1:0]       iframe_q [N_PLAYERS];
    logic [IfW-1:0]       iframe_d [N_PLAYERS];
    logic [HP_W:0]        heal_sum [N_PLAYERS];
    logic [11:0]          hp_color [N_PLAYERS];
    logic [N_PLAYERS-1:0] dead_q, dead_d;
    logic [N_PLAYERS-1:0] accept;
    logic [N_PLAYERS-1:0] hp_in, gh_in;
    logic [7:0]           frame_cnt_q, frame_cnt_d;
    logic                 vblnk_prev_q;
    logic                 frame_tick;
    logic                 unused_frame_cnt;

    logic [XW-1:0]        hc, vc;
    logic                 in_rows;
    logic [11:0]          pix_rgb;

    logic [10:0]          hcount_q, vcount_q;
    logic                 hsync_q, vsync_q, hblnk_q, vblnk_q;
    logic [11:0]          rgb_q;

    assign frame_tick       = vga_in.vblnk & ~vblnk_prev_q;
    assign frame_cnt_d      = round_rst_i ? 8'd0 : frame_cnt_q + {7'd0, frame_tick};
    assign unused_frame_cnt = ^frame_cnt_q;

    assign hc      = XW'(vga_in.hcount);
    assign vc      = XW'(vga_in.vcount);
    assign in_rows = (vc >= XW'(BAR_Y_START)) && (vc < XW'(BAR_Y_END));
    assign dead_o  = dead_q;

    for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_player
        localparam int unsigned Left = BAR_X0 + gi * BAR_PITCH;
        localparam logic [XW-1:0] LeftX  = XW'(Left);
        localparam logic [XW-1:0] RightX = XW'(Left + HEALTH_MAX);

        assign accept[gi]   = hit_i[gi] && (iframe_q[gi] == '0) && !dead_q[gi];
        assign heal_sum[gi] = {1'b0, hp_q[gi]} + (HP_W+1)'(HEAL_AMT);
        assign hp_o[gi*HP_W +: HP_W] = hp_q[gi];
        assign immune_o[gi] = |iframe_q[gi];

        // Even bars grow from their right edge, odd bars from their left edge.
        if ((gi % 2) == 0) begin : g_right
            assign hp_in[gi] = in_rows && (hc >= RightX - XW'(hp_q[gi])) && (hc < RightX);
            assign gh_in[gi] = in_rows && (hc >= RightX - XW'(ghost_q[gi])) && (hc < RightX);
        end else begin : g_left
            assign hp_in[gi] = in_rows && (hc >= LeftX) && (hc < LeftX + XW'(hp_q[gi]));
            assign gh_in[gi] = in_rows && (hc >= LeftX) && (hc < LeftX + XW'(ghost_q[gi]));
        end

`ifdef HP_BAR_FLASH_EN
        assign hp_color[gi] = (immune_o[gi] && frame_cnt_q[2]) ? 12'hFFF : BAR_COLOR;
`else
        assign hp_color[gi] = BAR_COLOR;
`endif
    end

    always_comb begin
        dead_d = dead_q;
        for (int i = 0; i < int'(N_PLAYERS); i++) begin
            hp_d[i]     = hp_q[i];
            ghost_d[i]  = ghost_q[i];
            iframe_d[i] = iframe_q[i];
            dead_d[i]   = dead_q[i] | (hp_q[i] == '0);

            if (accept[i]) begin
                hp_d[i]     = (hp_q[i] > dmg_i) ? hp_q[i] - dmg_i : '0;
                iframe_d[i] = IfW'(IFRAMES);
            end else begin
                if (heal_i[i] && !dead_q[i]) begin
                    hp_d[i] = (heal_sum[i] > (HP_W+1)'(HEALTH_MAX)) ? HP_W'(HEALTH_MAX)
                                                                     : heal_sum[i][HP_W-1:0];
                end
                if (frame_tick && (iframe_q[i] != '0)) begin
                    iframe_d[i] = iframe_q[i] - 1'b1;
                end
            end

            // Ghost never falls below live HP; it drains toward the post-update HP.
            if (ghost_d[i] < hp_d[i]) begin
                ghost_d[i] = hp_d[i];
            end
            if (frame_tick && (ghost_d[i] > hp_d[i])) begin
                if ((ghost_d[i] - hp_d[i]) > HP_W'(DRAIN_STEP)) begin
                    ghost_d[i] = ghost_d[i] - HP_W'(DRAIN_STEP);
                end else begin
                    ghost_d[i] = hp_d[i];
                end
            end

            if (round_rst_i) begin
                hp_d[i]     = HP_W'(HEALTH_MAX);
                ghost_d[i]  = HP_W'(HEALTH_MAX);
                iframe_d[i] = '0;
                dead_d[i]   = 1'b0;
            end
        end
    end

    // Descending scan so the lowest-indexed bar wins on overlap.
    always_comb begin
        pix_rgb = vga_in.rgb;
        for (int i = int'(N_PLAYERS) - 1; i >= 0; i--) begin
            if (hp_in[i]) begin
                pix_rgb = hp_color[i];
            end else if (gh_in[i]) begin
                pix_rgb = GHOST_COLOR;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_PLAYERS); i++) begin
                hp_q[i]     <= HP_W'(HEALTH_MAX);
                ghost_q[i]  <= HP_W'(HEALTH_MAX);
                iframe_q[i] <= '0;
            end
            dead_q       <= '0;
            frame_cnt_q  <= 8'd0;
            vblnk_prev_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(N_PLAYERS); i++) begin
                hp_q[i]     <= hp_d[i];
                ghost_q[i]  <= ghost_d[i];
                iframe_q[i] <= iframe_d[i];
            end
            dead_q       <= dead_d;
            frame_cnt_q  <= frame_cnt_d;
            vblnk_prev_q <= vga_in.vblnk;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_q <= '0;
            vcount_q <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            rgb_q    <= '0;
        end else begin
            hcount_q <= vga_in.hcount;
            vcount_q <= vga_in.vcount;
            hsync_q  <= vga_in.hsync;
            vsync_q  <= vga_in.vsync;
            hblnk_q  <= vga_in.hblnk;
            vblnk_q  <= vga_in.vblnk;
            rgb_q    <= pix_rgb;
        end
    end

    assign vga_out.hcount = hcount_q;
    assign vga_out.vcount = vcount_q;
    assign vga_out.hsync  = hsync_q;
    assign vga_out.vsync  = vsync_q;
    assign vga_out.hblnk  = hblnk_q;
    assign vga_out.vblnk  = vblnk_q;
    assign vga_out.rgb    = rgb_q;

endmodule

// File: tb/tb_hp_bar_array.sv
// tb_hp_bar_array: directed scenarios plus random traffic against an integer reference model.
module tb_hp_bar_array;

    logic        clk = 1'b0;
    logic        rst;
    logic        round_rst;
    logic [1:0]  hit, heal;
    logic [9:0]  dmg;
    logic [19:0] hp;
    logic [1:0]  dead, immune;

    vga_if vin ();
    vga_if vout ();

    hp_bar_array dut (
        .clk         (clk),
        .rst         (rst),
        .round_rst_i (round_rst),
        .hit_i       (hit),
        .dmg_i       (dmg),
        .heal_i      (heal),
        .hp_o        (hp),
        .dead_o      (dead),
        .immune_o    (immune),
        .vga_in      (vin),
        .vga_out     (vout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int   m_hp [2];
    int   m_gh [2];
    int   m_if [2];
    bit   m_dead [2];
    int   m_fc;
    bit   m_vprev;
    logic [11:0] exp_rgb;
    logic [25:0] exp_tim;

    task automatic model_reset(input bit full);
        for (int i = 0; i < 2; i++) begin
            m_hp[i] = 500; m_gh[i] = 500; m_if[i] = 0; m_dead[i] = 1'b0;
        end
        m_fc = 0;
        if (full) m_vprev = 1'b0;
    endtask

    function automatic logic [11:0] model_pix(input int hc, input int vc, input logic [11:0] bg);
        logic [11:0] c = bg;
        for (int i = 1; i >= 0; i--) begin
            int  l = 8 + i * 508;
            bit  hin, gin;
            if (i % 2 == 0) begin
                hin = hc >= l + 500 - m_hp[i] && hc < l + 500;
                gin = hc >= l + 500 - m_gh[i] && hc < l + 500;
            end else begin
                hin = hc >= l && hc < l + m_hp[i];
                gin = hc >= l && hc < l + m_gh[i];
            end
            if (!(vc >= 6 && vc < 26)) begin
                hin = 1'b0; gin = 1'b0;
            end
`ifdef HP_BAR_FLASH_EN
            if (hin) c = (m_if[i] != 0 && ((m_fc >> 2) & 1) == 1) ? 12'hFFF : 12'hF00;
`else
            if (hin) c = 12'hF00;
`endif
            else if (gin) c = 12'hFF0;
        end
        return c;
    endfunction

    function automatic logic [19:0] model_hp();
        return {10'(m_hp[1]), 10'(m_hp[0])};
    endfunction

    function automatic logic [1:0] model_immune();
        return {m_if[1] != 0, m_if[0] != 0};
    endfunction

    task automatic model_clock();
        bit tick = vin.vblnk && !m_vprev;
        if (round_rst) begin
            model_reset(1'b0);
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit now_dead = m_dead[i] || (m_hp[i] == 0);
                if (hit[i] && m_if[i] == 0 && !m_dead[i]) begin
                    m_hp[i] = (m_hp[i] > int'(dmg)) ? m_hp[i] - int'(dmg) : 0;
                    m_if[i] = 30;
                end else begin
                    if (heal[i] && !m_dead[i]) m_hp[i] = (m_hp[i] + 25 > 500) ? 500 : m_hp[i] + 25;
                    if (tick && m_if[i] > 0) m_if[i]--;
                end
                if (m_gh[i] < m_hp[i]) m_gh[i] = m_hp[i];
                if (tick && m_gh[i] > m_hp[i])
                    m_gh[i] -= (m_gh[i] - m_hp[i] < 2) ? m_gh[i] - m_hp[i] : 2;
                m_dead[i] = now_dead;
            end
            if (tick) m_fc = (m_fc + 1) % 256;
        end
        m_vprev = vin.vblnk;
    endtask

    // Advance one clock; records what vga_out must show afterwards.
    task automatic step();
        exp_rgb = model_pix(int'(vin.hcount), int'(vin.vcount), vin.rgb);
        exp_tim = {vin.hcount, vin.vcount, vin.hsync, vin.vsync, vin.hblnk, vin.vblnk};
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        vin.vblnk = 1'b1; step();
        vin.vblnk = 1'b0; step();
    endtask

    task automatic test_reset();
        logic [11:0] bg;
        rst = 1'b1; round_rst = 1'b0; hit = '0; heal = '0; dmg = '0;
        vin.hcount = 11'd0; vin.vcount = 11'd0; vin.hsync = 1'b0; vin.vsync = 1'b0;
        vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = 12'h000;
        model_reset(1'b1);
        #12;
        total++;
        if (hp !== {10'd500, 10'd500} || dead !== 2'b00 || immune !== 2'b00) begin
            bad++; $display("FAIL reset_state: hp=%h dead=%b immune=%b want hp=%h dead=00 immune=00",
                            hp, dead, immune, {10'd500, 10'd500});
        end
        total++;
        if ({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb} !== '0) begin
            bad++; $display("FAIL reset_vga_out: got rgb=%h hcount=%0d want all zero", vout.rgb, vout.hcount);
        end
        @(negedge clk); rst = 1'b0;
        bg = 12'($urandom_range(0, 12'h0EE));
        vin.rgb = bg; vin.vcount = 11'd10;
        vin.hcount = 11'd300; step();
        total++;
        if (vout.rgb !== 12'hF00 || vout.hcount !== 11'd300) begin
            bad++; $display("FAIL reset_bar0_mid: rgb=%h hcount=%0d want rgb=f00 hcount=300", vout.rgb, vout.hcount);
        end
        vin.hcount = 11'd30; step();
        total++;
        if (vout.rgb !== 12'hF00) begin
            bad++; $display("FAIL reset_bar0_left: rgb=%h want f00", vout.rgb);
        end
        vin.hcount = 11'd600; step();
        total++;
        if (vout.rgb !== 12'hF00) begin
            bad++; $display("FAIL reset_bar1: rgb=%h want f00", vout.rgb);
        end
        vin.hcount = 11'd300; vin.vcount = 11'd26; step();
        total++;
        if (vout.rgb !== bg) begin
            bad++; $display("FAIL reset_below_bar: rgb=%h want %h", vout.rgb, bg);
        end
    endtask

    task automatic test_hit_iframes();
        int ticks = 0;
        vin.vcount = 11'd10; vin.hcount = 11'd300; vin.rgb = 12'h00A;
        hit = 2'b01; dmg = 10'd120; step(); hit = '0;
        total++;
        if (hp[9:0] !== 10'd380 || immune[0] !== 1'b1) begin
            bad++; $display("FAIL hit_first: hp0=%0d immune0=%b want 380/1", hp[9:0], immune[0]);
        end
        repeat (5) begin frame(); ticks++; end
        hit = 2'b01; dmg = 10'd50; step(); hit = '0;
        total++;
        if (hp[9:0] !== 10'd380) begin
            bad++; $display("FAIL hit_while_immune: hp0=%0d want 380", hp[9:0]);
        end
        vin.hcount = 11'd127; step();
        total++;
        if (vout.rgb !== 12'hFF0) begin
            bad++; $display("FAIL ghost_early: rgb=%h want ff0", vout.rgb);
        end
        while (ticks < 29) begin frame(); ticks++; end
        total++;
        if (immune[0] !== 1'b1) begin
            bad++; $display("FAIL immune_29: immune0=%b want 1", immune[0]);
        end
        frame(); ticks++;
        total++;
        if (immune[0] !== 1'b0) begin
            bad++; $display("FAIL immune_30: immune0=%b want 0", immune[0]);
        end
        while (ticks < 59) begin frame(); ticks++; end
        step();
        total++;
        if (vout.rgb !== 12'hFF0) begin
            bad++; $display("FAIL ghost_59: rgb=%h want ff0", vout.rgb);
        end
        frame(); ticks++;
        step();
        total++;
        if (vout.rgb !== 12'h00A) begin
            bad++; $display("FAIL ghost_60: rgb=%h want 00a", vout.rgb);
        end
        vin.hcount = 11'd128; step();
        total++;
        if (vout.rgb !== 12'hF00) begin
            bad++; $display("FAIL hp_edge: rgb=%h want f00", vout.rgb);
        end
        hit = 2'b01; dmg = 10'd10; step(); hit = '0;
        total++;
        if (hp[9:0] !== 10'd370 || immune[0] !== 1'b1) begin
            bad++; $display("FAIL hit_after_expiry: hp0=%0d immune0=%b want 370/1", hp[9:0], immune[0]);
        end
    endtask

    task automatic test_death();
        round_rst = 1'b1; step(); round_rst = 1'b0;
        hit = 2'b10; dmg = 10'd460; step(); hit = '0;
        repeat (30) frame();
        total++;
        if (hp[19:10] !== 10'd40 || immune[1] !== 1'b0) begin
            bad++; $display("FAIL death_setup: hp1=%0d immune1=%b want 40/0", hp[19:10], immune[1]);
        end
        hit = 2'b10; dmg = 10'd100; step(); hit = '0;
        total++;
        if (hp[19:10] !== 10'd0 || dead[1] !== 1'b0) begin
            bad++; $display("FAIL death_hp0: hp1=%0d dead1=%b want 0/0", hp[19:10], dead[1]);
        end
        step();
        total++;
        if (dead[1] !== 1'b1) begin
            bad++; $display("FAIL death_flag: dead1=%b want 1", dead[1]);
        end
        heal = 2'b10; step(); heal = '0;
        total++;
        if (hp[19:10] !== 10'd0 || dead[1] !== 1'b1) begin
            bad++; $display("FAIL death_no_revive: hp1=%0d dead1=%b want 0/1", hp[19:10], dead[1]);
        end
        round_rst = 1'b1; step(); round_rst = 1'b0;
        total++;
        if (hp !== {10'd500, 10'd500} || dead !== 2'b00 || immune !== 2'b00) begin
            bad++; $display("FAIL round_rst: hp=%h dead=%b immune=%b want full/00/00", hp, dead, immune);
        end
    endtask

    task automatic test_same_cycle();
        hit = 2'b01; heal = 2'b01; dmg = 10'd30; step(); hit = '0; heal = '0;
        total++;
        if (hp[9:0] !== 10'd470) begin
            bad++; $display("FAIL hit_beats_heal: hp0=%0d want 470", hp[9:0]);
        end
        hit = 2'b01; heal = 2'b01; dmg = 10'd99; step(); hit = '0; heal = '0;
        total++;
        if (hp[9:0] !== 10'd495) begin
            bad++; $display("FAIL ignored_hit_heal: hp0=%0d want 495", hp[9:0]);
        end
        round_rst = 1'b1; step(); round_rst = 1'b0;
        hit = 2'b01; dmg = 10'd10; step(); hit = '0;
        heal = 2'b01; step(); heal = '0;
        vin.vcount = 11'd10; vin.hcount = 11'd8; vin.rgb = 12'h0B0; step();
        total++;
        if (hp[9:0] !== 10'd500 || immune[0] !== 1'b1 || vout.rgb !== 12'hF00) begin
            bad++; $display("FAIL heal_saturate: hp0=%0d immune0=%b rgb=%h want 500/1/f00",
                            hp[9:0], immune[0], vout.rgb);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            hit       = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            heal      = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            dmg       = 10'($urandom_range(0, 150));
            round_rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 2) == 0) vin.vblnk = ~vin.vblnk;
            vin.hcount = 11'($urandom_range(0, 1100));
            vin.vcount = 11'($urandom_range(0, 30));
            vin.hsync  = 1'($urandom); vin.vsync = 1'($urandom); vin.hblnk = 1'($urandom);
            vin.rgb    = 12'($urandom);
            step();
            total++;
            if (hp !== model_hp() || dead !== {m_dead[1], m_dead[0]} || immune !== model_immune()) begin
                bad++; $display("FAIL rand_state[%0d]: hp=%h dead=%b immune=%b want hp=%h dead=%b immune=%b",
                                n, hp, dead, immune, model_hp(), {m_dead[1], m_dead[0]}, model_immune());
            end
            total++;
            if (vout.rgb !== exp_rgb ||
                {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk} !== exp_tim) begin
                bad++; $display("FAIL rand_pixel[%0d]: rgb=%h hcount=%0d want rgb=%h hcount=%0d",
                                n, vout.rgb, vout.hcount, exp_rgb, exp_tim[25:15]);
            end
        end
        hit = '0; heal = '0; round_rst = 1'b0;
    endtask

    task automatic test_rst_mid_frame();
        vin.hcount = 11'd700; vin.vcount = 11'd12; vin.hsync = 1'b1; vin.vsync = 1'b1;
        vin.hblnk = 1'b1; vin.vblnk = 1'b0; vin.rgb = 12'h123;
        hit = 2'b11; dmg = 10'd50; step(); hit = '0;
        step();
        #2 rst = 1'b1;
        #1;
        model_reset(1'b1);
        total++;
        if ({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb} !== '0 ||
            hp !== {10'd500, 10'd500}) begin
            bad++; $display("FAIL rst_mid_frame: rgb=%h hcount=%0d hp=%h want zero outputs and full hp",
                            vout.rgb, vout.hcount, hp);
        end
        @(negedge clk); rst = 1'b0;
        vin.hcount = 11'd520; step();
        total++;
        if (vout.hcount !== 11'd520 || vout.rgb !== 12'hF00 || vout.hsync !== 1'b1 ||
            vout.vcount !== 11'd12) begin
            bad++; $display("FAIL rst_resume: hcount=%0d rgb=%h hsync=%b want 520/f00/1",
                            vout.hcount, vout.rgb, vout.hsync);
        end
    endtask

    initial begin
        test_reset();
        test_hit_iframes();
        test_death();
        test_same_cycle();
        test_random();
        test_rst_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hp_bar_array.md
Name: hp_bar_array

Overview:
- Parametrised health-bar engine for N players.
- Tracks per-player HP with variable damage, healing, invulnerability windows and a lagging "ghost" bar that drains per frame.
- Overlays all bars onto the VGA stream through a 1-cycle registered pipeline.
- Sits in the VGA draw chain after the background/sprite stages and feeds HP/death status to game control.

Parameters:
- N_PLAYERS, 2, number of bars/players.
- HP_W, 10, width of HP and damage values.
- HEALTH_MAX, 500, full HP; also full bar length in pixels.
- HEAL_AMT, 25, HP added per heal pulse.
- IFRAMES, 30, frames of hit immunity after an accepted hit.
- DRAIN_STEP, 2, ghost-bar pixels drained per frame.
- BAR_X0, 8, hcount of bar 0 left edge.
- BAR_PITCH, 508, hcount distance between successive bar left edges.
- BAR_Y_START, 6, first bar row (inclusive).
- BAR_Y_END, 26, last bar row (exclusive).
- BAR_COLOR, 12'hF00, live HP colour.
- GHOST_COLOR, 12'hFF0, drained-but-lagging colour.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous reset, active-high.
- round_rst  in  1  synchronous restart of all player state, same values as rst.
- hit  in  N_PLAYERS  per-player damage strobe, 1 cycle.
- dmg  in  HP_W  damage amount applied with any hit this cycle.
- heal  in  N_PLAYERS  per-player heal strobe, 1 cycle.
- hp  out  N_PLAYERS*HP_W  flattened current HP; player i at [i*HP_W +: HP_W].
- dead  out  N_PLAYERS  sticky: HP reached 0.
- immune  out  N_PLAYERS  invulnerability counter nonzero.
- vga_in  vga_if.vga_in  incoming timing + rgb.
- vga_out  vga_if.vga_out  outgoing timing + rgb, 1 cycle delayed.

Behaviour:
- Reset (rst async, or round_rst sync): hp=HEALTH_MAX, ghost=HEALTH_MAX, iframe counters=0, dead=0, immune=0, frame counter=0. On rst only, every vga_out field is also 0.
- Frame tick: 1-cycle pulse on the rising edge of vga_in.vblnk (registered previous value). Increments an 8-bit frame counter (wraps).
- Hit, player i, when hit[i] and iframe[i]==0 and !dead[i]:
  - hp <= (hp > dmg) ? hp-dmg : 0.
  - iframe <= IFRAMES.
  - hit with dmg==0 still loads IFRAMES.
  - While iframe[i]!=0, hits are ignored.
- Heal, when heal[i] and !dead[i] and no accepted hit that cycle: hp <= min(hp+HEAL_AMT, HEALTH_MAX). Use an HP_W+1-bit sum.
- hit and heal in the same cycle: an accepted hit wins and heal is dropped. An ignored hit (immune) lets the heal apply.
- dead[i] sets in the cycle after hp[i] becomes 0. It stays set until rst/round_rst; heal cannot revive.
- Ghost invariant: ghost >= hp at all times.
  - Heal raises ghost to the new hp when ghost < new hp, in the same cycle.
  - On frame tick, if ghost > hp: ghost <= ghost - min(DRAIN_STEP, ghost-hp), using hp after any same-cycle update.
- On frame tick, nonzero iframe counters decrement by 1. A hit load in the same cycle takes priority.
- Geometry: bar i occupies L_i = BAR_X0 + i*BAR_PITCH to L_i + HEALTH_MAX, rows BAR_Y_START..BAR_Y_END-1.
  - Even i is right-anchored: HP region is [L_i+HEALTH_MAX-hp, L_i+HEALTH_MAX).
  - Odd i is left-anchored: HP region is [L_i, L_i+hp).
  - Ghost region uses the same anchoring with ghost length.
- Pixel colour:
  - In an HP region: BAR_COLOR.
  - Else in a ghost region: GHOST_COLOR.
  - Else: vga_in.rgb.
  - Overlapping bars: the lowest index wins.
- Pipeline: vga_out hcount/vcount/hsync/vsync/hblnk/vblnk/rgb are all registered, 1-cycle latency, mutually aligned. Pixel decisions use hp/ghost values registered before the current cycle.

Optional Feature:
- Macro HP_BAR_FLASH_EN.
- Defined: while immune[i] and frame_counter[2]==1, bar i's HP region is drawn 12'hFFF instead of BAR_COLOR. Ghost region is unaffected.
- Undefined: no flash logic; HP region is always BAR_COLOR.

Test Plan:
- Reset, then a frame with hcount=300, vcount=10 -> vga_out.rgb=12'hF00 one cycle later. hcount=30 -> BAR_COLOR (bar 0 full). hp = {500,500}, dead=0.
- hit[0] with dmg=120 -> hp0=380, immune[0]=1.
  - Second hit[0] 5 frames later -> ignored, hp0=380.
  - After 30 frame ticks -> immune[0]=0, and a further hit is accepted.
- After the first hit: ghost0 drains 2 per frame. Pixel hcount=8+500-381 shows GHOST_COLOR until frame 60, then background. hcount=8+500-380 stays BAR_COLOR.
- hp1=40, then hit[1] with dmg=100 -> hp1=0, dead[1]=1 the next cycle. A following heal[1] -> hp1 stays 0. round_rst -> hp1=500, dead[1]=0.
- Same-cycle cases:
  - hit[0] (accepted) + heal[0] -> only damage applied.
  - With immune[0]=1, hp0=490, heal[0] -> hp0=500 (saturated), ghost0=500.
- Assert rst mid-frame -> all vga_out outputs 0 immediately. After release -> 1-cycle-delayed passthrough resumes and HP is full.
